memory_lookup_controller: RTL

Sequencing controller that sits directly upstream of the per-entry dynamic register arrays in the cache memory. It accepts GET/PUT/DELETE requests, scans the entries one per cycle over their shared tri-state read bus, and drives one-hot write and select strobes into the entries. It owns the authoritative valid bitmap: entry contents are meaningful only where the corresponding valid bit is set.

---
 rtl/memory_lookup_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/memory_lookup_controller.sv
// ============================================================================
// Module   : memory_lookup_controller
// Brief    : Sequences GET/PUT/DELETE requests over a scanned register-array cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_lookup_controller #(
    parameter int NUM_ENTRIES = 8,
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [1:0]                           req_op,
    input  logic [KEY_WIDTH-1:0]                 req_key,
    input  logic [VALUE_WIDTH-1:0]               req_value,
    output logic                                 resp_valid,
    input  logic                                 resp_ready,
    output logic                                 resp_hit,
    output logic                                 resp_err,
    output logic [VALUE_WIDTH-1:0]               resp_value,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]     occupancy,
    output logic [NUM_ENTRIES-1:0]               mem_write_op,
    output logic [NUM_ENTRIES-1:0]               mem_select_op,
    output logic [KEY_WIDTH+VALUE_WIDTH-1:0]     mem_data_in,
    input  logic [KEY_WIDTH+VALUE_WIDTH-1:0]     mem_data_out
);

    localparam int c_IDX_W  = $clog2(NUM_ENTRIES);
    localparam int c_OCC_W  = $clog2(NUM_ENTRIES + 1);
    localparam int c_DATA_W = KEY_WIDTH + VALUE_WIDTH;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_ENTRIES - 1);

    localparam logic [1:0] c_OP_GET = 2'b00;
    localparam logic [1:0] c_OP_PUT = 2'b01;
    localparam logic [1:0] c_OP_DEL = 2'b10;
    localparam logic [1:0] c_OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [1:0]               r_op;
    logic [KEY_WIDTH-1:0]     r_key;
    logic [VALUE_WIDTH-1:0]   r_value;
    logic [c_IDX_W-1:0]       r_idx;
    logic [c_IDX_W-1:0]       r_target;
    logic [NUM_ENTRIES-1:0]   r_valid;
    logic                     r_resp_hit;
    logic                     r_resp_err;
    logic [VALUE_WIDTH-1:0]   r_resp_value;

    logic                     w_hit;
    logic                     w_free_found;
    logic [c_IDX_W-1:0]       w_free_idx;
    logic [c_OCC_W-1:0]       w_occ;
    logic [NUM_ENTRIES-1:0]   w_scan_onehot;
    logic [NUM_ENTRIES-1:0]   w_target_onehot;

    // Stale contents of invalid entries must never produce a hit.
    assign w_hit = r_valid[r_idx] &&
                   (mem_data_out[c_DATA_W-1:VALUE_WIDTH] == r_key);

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_occ = w_occ + c_OCC_W'(r_valid[i]);
        end
    end

    always_comb begin
        w_scan_onehot            = '0;
        w_scan_onehot[r_idx]     = 1'b1;
        w_target_onehot          = '0;
        w_target_onehot[r_target] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem_select_op = '0;
        mem_write_op  = '0;
        mem_data_in   = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = (req_op == c_OP_RSV) ? S_RESP : S_SCAN;
                end
            end
            S_SCAN: begin
                mem_select_op = w_scan_onehot;
                if (w_hit) begin
                    w_state_next = (r_op == c_OP_PUT) ? S_WRITE : S_RESP;
                end else if (r_idx == c_LAST_IDX) begin
                    w_state_next = (r_op == c_OP_PUT && w_free_found) ? S_WRITE : S_RESP;
                end
            end
            S_WRITE: begin
                mem_write_op = w_target_onehot;
                mem_data_in  = {r_key, r_value};
                w_state_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= '0;
            r_key        <= '0;
            r_value      <= '0;
            r_idx        <= '0;
            r_target     <= '0;
            r_valid      <= '0;
            r_resp_hit   <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_value <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op         <= req_op;
                        r_key        <= req_key;
                        r_value      <= req_value;
                        r_idx        <= '0;
                        r_resp_hit   <= 1'b0;
                        r_resp_err   <= (req_op == c_OP_RSV);
                        r_resp_value <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_hit) begin
                        r_target   <= r_idx;
                        r_resp_hit <= 1'b1;
                        if (r_op == c_OP_GET) begin
                            r_resp_value <= mem_data_out[VALUE_WIDTH-1:0];
                        end
                        if (r_op == c_OP_DEL) begin
                            r_valid[r_idx] <= 1'b0;
                        end
                    end else if (r_idx != c_LAST_IDX) begin
                        r_idx <= r_idx + 1'b1;
                    end else if (r_op == c_OP_PUT) begin
                        // New key lands in the lowest free slot; a full table is an error.
                        if (w_free_found) begin
                            r_target <= w_free_idx;
                        end else begin
                            r_resp_err <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_valid[r_target] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign resp_hit   = r_resp_hit;
    assign resp_err   = r_resp_err;
    assign resp_value = r_resp_value;
    assign occupancy  = w_occ;

endmodule

`default_nettype wire
